// File: rtl/pnseq_burst_ctrl.sv
// pnseq_burst_ctrl
//
// Burst sequencer for a gen_lfsr PN generator. An accepted start latches the
// PN configuration. The LFSR is reloaded from the seed before every
// repetition, so all repetitions are bit-identical. Each chip is streamed on
// an AXI-stream-style output, with o_tlast on the final chip of a sequence.
//
// Build option:
//   PNSEQ_CTRL_GAP_EN  when defined, cfg_gap idle cycles are inserted between
//                      repetitions (GAP state). When undefined, cfg_gap is
//                      ignored and repetitions are separated only by the LOAD
//                      cycle.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   start, abort          burst request (sampled in IDLE only) / immediate stop
//   cfg_poly/seed/order   LFSR configuration, latched on an accepted start
//   cfg_period/reps/gap   chips per sequence, sequences per burst, gap cycles
//   lfsr_load, lfsr_en    gen_lfsr control pins
//   lfsr_poly/seed/order  latched configuration forwarded to gen_lfsr
//   lfsr_pnseq            chip from gen_lfsr
//   o_tdata/tvalid/tlast  chip stream; o_tready is the downstream ready
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse on normal burst completion
module pnseq_burst_ctrl #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_poly,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [3:0]       cfg_order,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_reps,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic [WIDTH-1:0] lfsr_poly,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic [3:0]       lfsr_order,
  input  logic             lfsr_pnseq,
  output logic             o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_tlast,
  output logic             busy,
  output logic             done
);

`ifdef PNSEQ_CTRL_GAP_EN
  typedef enum logic [1:0] {StIdle, StLoad, StRun, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] chip_cnt_q, chip_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [3:0]       order_q, order_d;
  logic             done_q, done_d;

  logic run;
  logic hs;
  logic last_chip;
  logic last_rep;

`ifdef PNSEQ_CTRL_GAP_EN
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  logic unused_cfg_gap;
  assign unused_cfg_gap = ^cfg_gap;
`endif

  assign run       = (state_q == StRun);
  assign hs        = run & o_tready;
  assign last_chip = (chip_cnt_q == period_q - CNT_W'(1));
  assign last_rep  = (rep_cnt_q == reps_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    chip_cnt_d = chip_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    period_d   = period_q;
    reps_d     = reps_q;
    poly_d     = poly_q;
    seed_d     = seed_q;
    order_d    = order_q;
    done_d     = 1'b0;
`ifdef PNSEQ_CTRL_GAP_EN
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((cfg_period != '0) && (cfg_reps != '0)) begin
            poly_d     = cfg_poly;
            seed_d     = cfg_seed;
            order_d    = cfg_order;
            period_d   = cfg_period;
            reps_d     = cfg_reps;
`ifdef PNSEQ_CTRL_GAP_EN
            gap_d      = cfg_gap;
`endif
            chip_cnt_d = '0;
            rep_cnt_d  = '0;
            state_d    = StLoad;
          end else begin
            // Empty burst: acknowledge completion without streaming anything.
            done_d = 1'b1;
          end
        end
      end

      StLoad: state_d = StRun;

      StRun: begin
        if (hs) begin
          if (last_chip) begin
            chip_cnt_d = '0;
            if (last_rep) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              rep_cnt_d = rep_cnt_q + CNT_W'(1);
`ifdef PNSEQ_CTRL_GAP_EN
              if (gap_q != '0) begin
                gap_cnt_d = gap_q;
                state_d   = StGap;
              end else begin
                state_d = StLoad;
              end
`else
              state_d = StLoad;
`endif
            end
          end else begin
            chip_cnt_d = chip_cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef PNSEQ_CTRL_GAP_EN
      StGap: begin
        // Entered with the count at gap (>0); leaves after exactly gap cycles.
        gap_cnt_d = gap_cnt_q - CNT_W'(1);
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d = StLoad;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      chip_cnt_q <= '0;
      rep_cnt_q  <= '0;
      period_q   <= '0;
      reps_q     <= '0;
      poly_q     <= '0;
      seed_q     <= '0;
      order_q    <= '0;
      done_q     <= 1'b0;
`ifdef PNSEQ_CTRL_GAP_EN
      gap_q      <= '0;
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      chip_cnt_q <= chip_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      period_q   <= period_d;
      reps_q     <= reps_d;
      poly_q     <= poly_d;
      seed_q     <= seed_d;
      order_q    <= order_d;
      done_q     <= done_d;
`ifdef PNSEQ_CTRL_GAP_EN
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  // The LFSR only advances on a handshake, so a stall holds the chip stable.
  assign o_tvalid   = run;
  assign o_tdata    = run & lfsr_pnseq;
  assign o_tlast    = run & last_chip;
  assign lfsr_en    = hs;
  assign lfsr_load  = (state_q == StLoad);
  assign lfsr_poly  = poly_q;
  assign lfsr_seed  = seed_q;
  assign lfsr_order = order_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_pnseq_burst_ctrl.sv
// Self-checking bench for pnseq_burst_ctrl. A simple gen_lfsr stand-in feeds
// lfsr_pnseq; expected chips come from the linear recurrence the polynomial
// defines, restarted from the seed at each repetition.
module tb_pnseq_burst_ctrl;
  localparam int WIDTH = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [WIDTH-1:0] cfg_poly, cfg_seed;
  logic [3:0]       cfg_order;
  logic [CNT_W-1:0] cfg_period, cfg_reps, cfg_gap;
  logic             lfsr_load, lfsr_en;
  logic [WIDTH-1:0] lfsr_poly, lfsr_seed;
  logic [3:0]       lfsr_order;
  logic             lfsr_pnseq;
  logic             o_tdata, o_tvalid, o_tready, o_tlast, busy, done;

  int total = 0;
  int bad   = 0;
  bit exp_a [0:1023];

  always #5 clk = ~clk;

  pnseq_burst_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_poly   (cfg_poly),
    .cfg_seed   (cfg_seed),
    .cfg_order  (cfg_order),
    .cfg_period (cfg_period),
    .cfg_reps   (cfg_reps),
    .cfg_gap    (cfg_gap),
    .lfsr_load  (lfsr_load),
    .lfsr_en    (lfsr_en),
    .lfsr_poly  (lfsr_poly),
    .lfsr_seed  (lfsr_seed),
    .lfsr_order (lfsr_order),
    .lfsr_pnseq (lfsr_pnseq),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .o_tlast    (o_tlast),
    .busy       (busy),
    .done       (done)
  );

  // gen_lfsr stand-in: shift left, feedback into bit 0, output bit order-1.
  logic [WIDTH-1:0] lfsr_r = '0;
  logic [WIDTH-1:0] omask;
  always_comb begin
    omask      = '0;
    lfsr_pnseq = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < int'(lfsr_order)) omask[k] = 1'b1;
      if (k == int'(lfsr_order) - 1) lfsr_pnseq = lfsr_r[k];
    end
  end
  always_ff @(posedge clk) begin
    if (lfsr_load) lfsr_r <= lfsr_seed;
    else if (lfsr_en) lfsr_r <= {lfsr_r[WIDTH-2:0], ^(lfsr_r & lfsr_poly & omask)};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // a[i] = seed[order-1-i] for i < order; a[i] = XOR of a[i-1-k] over taps k.
  function automatic void build_model(input logic [WIDTH-1:0] poly, input logic [WIDTH-1:0] seed,
                                      input int order, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < order) begin
        exp_a[i] = seed[order-1-i];
      end else begin
        bit b;
        b = 1'b0;
        for (int k = 0; k < order; k++) if (poly[k]) b ^= exp_a[i-1-k];
        exp_a[i] = b;
      end
    end
  endfunction

  task automatic do_start(input logic [WIDTH-1:0] poly, input logic [WIDTH-1:0] seed,
                          input int order, input int period, input int reps, input int gap);
    @(negedge clk);
    cfg_poly   = poly;
    cfg_seed   = seed;
    cfg_order  = 4'(order);
    cfg_period = CNT_W'(period);
    cfg_reps   = CNT_W'(reps);
    cfg_gap    = CNT_W'(gap);
    start      = 1'b1;
    o_tready   = 1'b1;
    build_model(poly, seed, order, period);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_busy", 32'(busy), 1);
    check("start_load", 32'(lfsr_load), 1);
    check("start_valid", 32'(o_tvalid), 0);
    check("start_en", 32'(lfsr_en), 0);
    check("latched_poly", 32'(lfsr_poly), 32'(poly));
    check("latched_seed", 32'(lfsr_seed), 32'(seed));
    check("latched_order", 32'(lfsr_order), order);
  endtask

  // Follows one burst cycle by cycle from the first RUN cycle (start edge + 2).
  task automatic watch(input int period, input int reps, input int gap, input bit rnd,
                       input int abort_at, input int rst_at, input int restart_at,
                       output int ones);
    int chip = 0, rep = 0, hs_cnt = 0, dead = 0, cyc = 0, exp_dead;
    bit dead_on = 0, fin = 0, ab = 0, rs = 0;
    bit pend_abort = 0, pend_rst = 0, pend_start = 0;
`ifdef PNSEQ_CTRL_GAP_EN
    exp_dead = gap + 1;
`else
    exp_dead = 1;
`endif
    ones = 0;
    forever begin
      @(negedge clk);
      abort    = pend_abort;
      rst      = pend_rst;
      start    = pend_start;
      if (pend_start) begin
        cfg_poly   = WIDTH'($urandom);
        cfg_seed   = WIDTH'($urandom);
        cfg_order  = 4'($urandom_range(2, 10));
        cfg_period = CNT_W'($urandom_range(1, 9));
        cfg_reps   = CNT_W'($urandom_range(1, 3));
        cfg_gap    = CNT_W'($urandom_range(0, 7));
      end
      pend_abort = 0;
      pend_rst   = 0;
      pend_start = 0;
      o_tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      if (rs) begin
        check("rst_valid", 32'(o_tvalid), 0);
        check("rst_last", 32'(o_tlast), 0);
        check("rst_data", 32'(o_tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_load", 32'(lfsr_load), 0);
        check("rst_en", 32'(lfsr_en), 0);
        check("rst_poly", 32'(lfsr_poly), 0);
        check("rst_seed", 32'(lfsr_seed), 0);
        check("rst_order", 32'(lfsr_order), 0);
        return;
      end
      if (ab) begin
        check("abort_valid", 32'(o_tvalid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_load", 32'(lfsr_load), 0);
        @(negedge clk);
        #1;
        check("abort_done2", 32'(done), 0);
        check("abort_valid2", 32'(o_tvalid), 0);
        return;
      end
      if (fin) begin
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_valid", 32'(o_tvalid), 0);
        @(negedge clk);
        #1;
        check("done_clear", 32'(done), 0);
        return;
      end
      if (cyc > 5000) begin
        check("timeout", 0, 1);
        return;
      end
      check("done_early", 32'(done), 0);
      check("en_handshake", 32'(lfsr_en), 32'(o_tvalid & o_tready));
      check("load_en_excl", 32'(lfsr_en & lfsr_load), 0);
      if (!dead_on) check("valid", 32'(o_tvalid), 1);
      if (o_tvalid) begin
        if (dead_on) begin
          check("dead_cycles", dead, exp_dead);
          dead_on = 0;
        end
        check("chip_data", 32'(o_tdata), 32'(exp_a[chip]));
        check("chip_last", 32'(o_tlast), 32'(chip == period - 1));
        if (abort) ab = 1;
        else if (rst) rs = 1;
        else if (o_tready) begin
          if (rep == 0) ones += int'(o_tdata);
          hs_cnt++;
          if (chip == period - 1) begin
            chip = 0;
            rep++;
            if (rep == reps) fin = 1;
            else begin
              dead_on = 1;
              dead    = 0;
            end
          end else begin
            chip++;
          end
          if (hs_cnt == abort_at) pend_abort = 1;
          if (hs_cnt == rst_at) pend_rst = 1;
          if (hs_cnt == restart_at) pend_start = 1;
        end
      end else begin
        check("idle_last", 32'(o_tlast), 0);
        if (dead_on) dead++;
      end
    end
  endtask

  task automatic degenerate(input int period, input int reps);
    @(negedge clk);
    cfg_period = CNT_W'(period);
    cfg_reps   = CNT_W'(reps);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("deg_done", 32'(done), 1);
    check("deg_busy", 32'(busy), 0);
    check("deg_valid", 32'(o_tvalid), 0);
    @(negedge clk);
    #1;
    check("deg_done_clr", 32'(done), 0);
    check("deg_valid2", 32'(o_tvalid), 0);
    check("deg_load", 32'(lfsr_load), 0);
  endtask

  localparam logic [WIDTH-1:0] BasePoly = 10'b0000110000;
  localparam logic [WIDTH-1:0] BaseSeed = 10'b0000010000;

  initial begin
    int ones;
    int ord, per;
    logic [WIDTH-1:0] p, s;
    rst = 1'b1; start = 1'b0; abort = 1'b0; o_tready = 1'b1;
    cfg_poly = '0; cfg_seed = '0; cfg_order = '0;
    cfg_period = '0; cfg_reps = '0; cfg_gap = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_valid", 32'(o_tvalid), 0);
    check("reset_last", 32'(o_tlast), 0);
    check("reset_data", 32'(o_tdata), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_load", 32'(lfsr_load), 0);
    check("reset_en", 32'(lfsr_en), 0);
    check("reset_poly", 32'(lfsr_poly), 0);
    check("reset_seed", 32'(lfsr_seed), 0);
    check("reset_order", 32'(lfsr_order), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic burst: two 63-chip m-sequences of x^6+x^5+1.
    do_start(BasePoly, BaseSeed, 6, 63, 2, 4);
    watch(63, 2, 4, 1'b0, -1, -1, -1, ones);
    check("mseq_ones", ones, 32);

    // Backpressure.
    do_start(BasePoly, BaseSeed, 6, 63, 2, 4);
    watch(63, 2, 4, 1'b1, -1, -1, -1, ones);
    check("bp_ones", ones, 32);

    // Abort at chip 20 of the second repetition, then a clean rerun.
    do_start(BasePoly, BaseSeed, 6, 63, 2, 4);
    watch(63, 2, 4, 1'b0, 83, -1, -1, ones);
    do_start(BasePoly, BaseSeed, 6, 63, 2, 4);
    watch(63, 2, 4, 1'b0, -1, -1, -1, ones);

    // Degenerate configurations.
    degenerate(0, 2);
    degenerate(5, 0);

    // Start re-pulsed mid-burst with scrambled configuration.
    do_start(BasePoly, BaseSeed, 6, 63, 2, 4);
    watch(63, 2, 4, 1'b1, -1, -1, 40, ones);
    check("restart_poly", 32'(lfsr_poly), 32'(BasePoly));
    check("restart_seed", 32'(lfsr_seed), 32'(BaseSeed));

    // Reset mid-run, then a fresh burst.
    do_start(BasePoly, BaseSeed, 6, 63, 2, 4);
    watch(63, 2, 4, 1'b0, -1, 30, -1, ones);
    @(negedge clk);
    rst = 1'b0;
    do_start(BasePoly, BaseSeed, 6, 63, 2, 0);
    watch(63, 2, 0, 1'b1, -1, -1, -1, ones);

    // Single-chip sequences, no gap.
    do_start(BasePoly, BaseSeed, 6, 1, 3, 0);
    watch(1, 3, 0, 1'b1, -1, -1, -1, ones);

    // Random configurations with random backpressure.
    for (int t = 0; t < 4; t++) begin
      ord = int'($urandom_range(3, 10));
      p   = WIDTH'($urandom) & WIDTH'((1 << ord) - 1);
      p[ord-1] = 1'b1;
      s   = WIDTH'($urandom) & WIDTH'((1 << ord) - 1);
      s[0] = 1'b1;
      per = int'($urandom_range(2, 40));
      do_start(p, s, ord, per, t + 1, t);
      watch(per, t + 1, t, 1'b1, -1, -1, -1, ones);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
